// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory: loader FSM states, sizes and
// the big-endian byte-lane order also assumed by the read path.
package imem_pkg;

  localparam int IMEM_ADDR_WIDTH = 16;
  localparam int BYTES_PER_WORD  = 4;
  localparam int BYTE0_LSB       = 24;  // byte0 lands in [31:24]

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  // Shifting left keeps the earliest byte in the most significant lane.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                input logic [7:0]  b);
    return {word[BYTE0_LSB-1:0], b};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into big-endian 32-bit words; word_full flags the byte
// that completes a word, and word already includes that byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] shift_reg;
  logic [1:0]  lane_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      lane_reg  <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      lane_reg  <= '0;
    end else if (shift_en) begin
      shift_reg <= shift_in_byte(shift_reg, data);
      lane_reg  <= lane_reg + 2'd1;
    end
  end

  assign word      = shift_in_byte(shift_reg, data);
  assign word_full = shift_en && (lane_reg == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as consecutive big-endian words and
// keeps the CPU held until the requested word count has been written.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length_words,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold,
  output logic                  wrap_err
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] TOP_WORD  = ~ADDR_WIDTH'(3);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] ptr_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LEN_WIDTH-1:0]  remaining_reg;
  logic [31:0]           wdata_reg;
  logic                  wrap_reg;

  logic        start_ok;
  logic        shift_en;
  logic [31:0] packed_word;
  logic        word_full;

  assign start_ok = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign shift_en = in_valid && (state_reg == COLLECT);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .shift_en  (shift_en),
    .data      (in_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start)
          state_next = (length_words == '0) ? DONE : COLLECT;
      end
      COLLECT: begin
        if (word_full)
          state_next = WRITE;
      end
      WRITE: begin
        state_next = (remaining_reg == LEN_WIDTH'(1)) ? DONE : COLLECT;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      addr_reg      <= '0;
      remaining_reg <= '0;
      wdata_reg     <= '0;
      wrap_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        ptr_reg       <= base_addr & WORD_MASK;
        remaining_reg <= length_words;
        wrap_reg      <= 1'b0;
      end
      // Write port registers are loaded as the word completes so they are
      // stable for the whole WRITE cycle and hold afterwards.
      if (state_reg == COLLECT && word_full) begin
        addr_reg  <= ptr_reg;
        wdata_reg <= packed_word;
      end
      if (state_reg == WRITE) begin
        ptr_reg       <= ptr_reg + ADDR_WIDTH'(4);
        remaining_reg <= remaining_reg - LEN_WIDTH'(1);
        if (remaining_reg != LEN_WIDTH'(1) && ptr_reg == TOP_WORD)
          wrap_reg <= 1'b1;
      end
    end
  end

  assign in_ready  = (state_reg == COLLECT);
  assign mem_we    = (state_reg == WRITE);
  assign busy      = (state_reg == COLLECT) || (state_reg == WRITE);
  assign done      = (state_reg == DONE);
  assign cpu_hold  = (state_reg != DONE);
  assign wrap_err  = wrap_reg;
  assign mem_addr  = 32'(addr_reg);
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: packing order, addressing, wrap flag,
// zero-length loads, reset mid-word and ignored starts.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [13:0] length_words = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, mem_we, busy, done, cpu_hold, wrap_err;
  logic [31:0] mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int t0    = 0;

  imem_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .length_words (length_words),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .cpu_hold     (cpu_hold),
    .wrap_err     (wrap_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] b, input logic [13:0] n);
    start = 1'b1;
    base_addr = b;
    length_words = n;
    tick();
    start = 1'b0;
    $display("start base=0x%04h len=%0d", b, n);
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input string tag, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      send(w[31-8*i -: 8]);
      if (i < 3) chk($sformatf("%s.nowe%0d", tag, i), 32'(mem_we), 32'd0);
    end
  endtask

  task automatic expect_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk($sformatf("%s.we", tag), 32'(mem_we), 32'd1);
    chk($sformatf("%s.rdy", tag), 32'(in_ready), 32'd0);
    chk($sformatf("%s.addr", tag), mem_addr, a);
    chk($sformatf("%s.data", tag), mem_wdata, d);
    $display("write 0x%08h @ 0x%08h (%s)", mem_wdata, mem_addr, tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle behaviour
    repeat (2) tick();
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.cpu_hold", 32'(cpu_hold), 32'd1);
    chk("rst.wrap_err", 32'(wrap_err), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(8'h5A);
      chk("idle.mem_we", 32'(mem_we), 32'd0);
      chk("idle.in_ready", 32'(in_ready), 32'd0);
      chk("idle.cpu_hold", 32'(cpu_hold), 32'd1);
    end

    // Two words, continuous stream
    do_start(16'h0000, 14'd2);
    t0 = cyc;
    chk("t2.in_ready", 32'(in_ready), 32'd1);
    chk("t2.busy", 32'(busy), 32'd1);
    send_word("t2w0", 32'h01020304);
    expect_write("t2w0", 32'h0000_0000, 32'h0102_0304);
    chk("t2.back_collect", 32'(in_ready), 32'd1);
    send_word("t2w1", 32'h05060708);
    expect_write("t2w1", 32'h0000_0004, 32'h0506_0708);
    chk("t2.done", 32'(done), 32'd1);
    chk("t2.cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t2.busy", 32'(busy), 32'd0);
    chk("t2.cycles", 32'(cyc - t0), 32'd10);
    chk("t2.hold_addr", mem_addr, 32'h0000_0004);
    chk("t2.hold_data", mem_wdata, 32'h0506_0708);

    // Unaligned base, gaps in the stream
    do_start(16'h0013, 14'd1);
    chk("t3.done_fall", 32'(done), 32'd0);
    chk("t3.cpu_hold", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3.gap_we", 32'(mem_we), 32'd0);
      send(8'hAA + 8'(i * 17));
      if (i < 3) chk("t3.byte_we", 32'(mem_we), 32'd0);
    end
    expect_write("t3", 32'h0000_0010, 32'hAABB_CCDD);
    chk("t3.done", 32'(done), 32'd1);

    // Wrap past the top of memory
    do_start(16'hFFFC, 14'd2);
    send_word("t4w0", 32'h11223344);
    expect_write("t4w0", 32'h0000_FFFC, 32'h1122_3344);
    chk("t4.wrap_set", 32'(wrap_err), 32'd1);
    send_word("t4w1", 32'h55667788);
    expect_write("t4w1", 32'h0000_0000, 32'h5566_7788);
    chk("t4.done", 32'(done), 32'd1);
    chk("t4.wrap_sticky", 32'(wrap_err), 32'd1);
    do_start(16'hFFFC, 14'd1);
    chk("t4.wrap_clr", 32'(wrap_err), 32'd0);
    chk("t4.busy", 32'(busy), 32'd1);
    send_word("t4w2", 32'h99AABBCC);
    expect_write("t4w2", 32'h0000_FFFC, 32'h99AA_BBCC);
    chk("t4.last_top_nowrap", 32'(wrap_err), 32'd0);
    chk("t4.done2", 32'(done), 32'd1);

    // Reset in the middle of a word
    do_start(16'h0100, 14'd1);
    send(8'hE1);
    send(8'hE2);
    rst_n = 1'b0;
    #2;
    chk("t5.rst_busy", 32'(busy), 32'd0);
    chk("t5.rst_ready", 32'(in_ready), 32'd0);
    chk("t5.rst_hold", 32'(cpu_hold), 32'd1);
    chk("t5.rst_addr", mem_addr, 32'd0);
    chk("t5.rst_data", mem_wdata, 32'd0);
    tick();
    rst_n = 1'b1;

    // Zero-length load from IDLE
    do_start(16'h0040, 14'd0);
    chk("t6.done", 32'(done), 32'd1);
    chk("t6.cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t6.mem_we", 32'(mem_we), 32'd0);
    chk("t6.busy", 32'(busy), 32'd0);

    // Fresh load, with a start pulse mid-word that must be ignored
    do_start(16'h0100, 14'd1);
    send(8'hA1);
    start = 1'b1;
    base_addr = 16'h0200;
    length_words = 14'd5;
    send(8'hA2);
    start = 1'b0;
    chk("t7.busy", 32'(busy), 32'd1);
    send(8'hA3);
    chk("t7.nowe", 32'(mem_we), 32'd0);
    send(8'hA4);
    expect_write("t7", 32'h0000_0100, 32'hA1A2_A3A4);
    chk("t7.done", 32'(done), 32'd1);
    send(8'hEE);
    chk("t7.dn_we", 32'(mem_we), 32'd0);
    chk("t7.dn_ready", 32'(in_ready), 32'd0);
    chk("t7.dn_hold_data", mem_wdata, 32'hA1A2_A3A4);
    chk("t7.dn_done", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
